// File: rtl/csi2_delay_calib.sv
// csi2_delay_calib
//   Per-lane IDELAY calibration for the CSI-2 receiver. Sweeps one lane's tap
//   over 0..2^TAP_WIDTH-1 while the others hold, grades each tap by watching
//   header/CRC error pulses over DWELL_FRAMES frames, then programs every lane
//   to the centre of its widest error-free tap window.
// Ports
//   clk_i, rst_i          pixel clock, async active-high reset
//   start_i               start pulse (ignored while busy)
//   frame_start_i         one pulse per frame
//   header_err_i, crc_err_i  receiver error pulses
//   lane_delay_o          per-lane tap, packed [DATA_LANES-1:0][TAP_WIDTH-1:0]
//   delay_act_o           one-cycle load strobe for lane_delay_o
//   busy_o, done_o        calibration in progress / completion pulse
//   lane_fail_o           lane had no window of at least MIN_WINDOW taps
module csi2_delay_calib #(
  parameter int DATA_LANES     = 2,
  parameter int TAP_WIDTH      = 5,
  parameter int DEFAULT_TAP    = 16,
  parameter int SETTLE_CYCLES  = 64,
  parameter int DWELL_FRAMES   = 2,
  parameter int TIMEOUT_CYCLES = 2**20,
  parameter int MIN_WINDOW     = 3
) (
  input  logic                                  clk_i,
  input  logic                                  rst_i,
  input  logic                                  start_i,
  input  logic                                  frame_start_i,
  input  logic                                  header_err_i,
  input  logic                                  crc_err_i,
  output logic [DATA_LANES-1:0][TAP_WIDTH-1:0]  lane_delay_o,
  output logic                                  delay_act_o,
  output logic                                  busy_o,
  output logic                                  done_o,
  output logic [DATA_LANES-1:0]                 lane_fail_o
);

  localparam int LW  = (DATA_LANES > 1) ? $clog2(DATA_LANES) : 1;
  localparam int TMW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int SCW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES + 1) : 1;
  localparam int FCW = (DWELL_FRAMES > 1) ? $clog2(DWELL_FRAMES + 1) : 1;
  localparam logic [TAP_WIDTH-1:0] TAP_MAX = '1;
  localparam logic [TAP_WIDTH-1:0] DEF     = TAP_WIDTH'(DEFAULT_TAP);
  localparam logic [TAP_WIDTH:0]   MINW    = (TAP_WIDTH+1)'(MIN_WINDOW);

  typedef enum logic [2:0] {
    S_IDLE, S_APPLY, S_SETTLE, S_SYNC, S_MEASURE, S_EVAL, S_FINAL
  } state_t;

  state_t r_state, w_next;

  logic [LW-1:0]                        r_k;
  logic [TAP_WIDTH-1:0]                 r_tap;
  logic [TAP_WIDTH-1:0]                 r_cur_start, r_best_start;
  logic [TAP_WIDTH:0]                   r_cur_len, r_best_len;
  logic [SCW-1:0]                       r_settle;
  logic [TMW-1:0]                       r_timer;
  logic [FCW-1:0]                       r_frames;
  logic                                 r_err;   // current tap is bad
  logic [DATA_LANES-1:0][TAP_WIDTH-1:0] r_res;

  logic                                 w_err_in, w_timeout, w_close;
  logic                                 w_last_tap, w_last_lane, w_lane_fail;
  logic [TAP_WIDTH-1:0]                 w_cur_start_n, w_best_start_n, w_center, w_result;
  logic [TAP_WIDTH:0]                   w_cur_len_n, w_best_len_n, w_best_m1;
  logic [DATA_LANES-1:0][TAP_WIDTH-1:0] w_apply;

  assign w_err_in    = header_err_i | crc_err_i;
  // A frame start in the same cycle clears the timer, so it wins over timeout.
  assign w_timeout   = (r_timer == TMW'(TIMEOUT_CYCLES - 1)) && !frame_start_i;
  assign w_close     = frame_start_i && (r_frames == FCW'(DWELL_FRAMES - 1));
  assign w_last_tap  = (r_tap == TAP_MAX);
  assign w_last_lane = (r_k == LW'(DATA_LANES - 1));

  // Run tracker update for the tap being graded; also used at sweep end so a
  // run reaching the last tap is closed before the centre is taken.
  always_comb begin
    w_cur_start_n  = r_cur_start;
    w_cur_len_n    = r_cur_len;
    w_best_start_n = r_best_start;
    w_best_len_n   = r_best_len;
    if (!r_err) begin
      if (r_cur_len == '0) w_cur_start_n = r_tap;
      w_cur_len_n = r_cur_len + 1'b1;
      if (w_cur_len_n > r_best_len) begin
        w_best_start_n = w_cur_start_n;
        w_best_len_n   = w_cur_len_n;
      end
    end else begin
      w_cur_len_n = '0;
    end
    w_best_m1   = w_best_len_n - 1'b1;
    w_center    = w_best_start_n + TAP_WIDTH'(w_best_m1 >> 1);
    w_lane_fail = (w_best_len_n < MINW);
    w_result    = w_lane_fail ? DEF : w_center;
  end

  // Finished lanes show their result, pending lanes their pre-start value.
  always_comb begin
    w_apply      = r_res;
    w_apply[r_k] = r_tap;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:    if (start_i) w_next = S_APPLY;
      S_APPLY:   w_next = S_SETTLE;
      S_SETTLE:  if (r_settle == SCW'(SETTLE_CYCLES - 1)) w_next = S_SYNC;
      S_SYNC:    if (frame_start_i) w_next = S_MEASURE;
                 else if (w_timeout) w_next = S_EVAL;
      S_MEASURE: if (w_close || w_timeout) w_next = S_EVAL;
      S_EVAL:    w_next = (w_last_tap && w_last_lane) ? S_FINAL : S_APPLY;
      S_FINAL:   w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      lane_delay_o <= {DATA_LANES{DEF}};
      delay_act_o  <= 1'b0;
      busy_o       <= 1'b0;
      done_o       <= 1'b0;
      lane_fail_o  <= '0;
      r_k          <= '0;
      r_tap        <= '0;
      r_cur_start  <= '0;
      r_cur_len    <= '0;
      r_best_start <= '0;
      r_best_len   <= '0;
      r_settle     <= '0;
      r_timer      <= '0;
      r_frames     <= '0;
      r_err        <= 1'b0;
      r_res        <= {DATA_LANES{DEF}};
    end else begin
      delay_act_o <= 1'b0;
      done_o      <= 1'b0;
      case (r_state)
        S_IDLE: if (start_i) begin
          busy_o       <= 1'b1;
          lane_fail_o  <= '0;
          r_k          <= '0;
          r_tap        <= '0;
          r_cur_start  <= '0;
          r_cur_len    <= '0;
          r_best_start <= '0;
          r_best_len   <= '0;
          r_res        <= lane_delay_o;
        end
        S_APPLY: begin
          lane_delay_o <= w_apply;
          delay_act_o  <= 1'b1;
          r_settle     <= '0;
        end
        S_SETTLE: begin
          r_settle <= r_settle + 1'b1;
          r_timer  <= '0;
        end
        S_SYNC: begin
          if (frame_start_i) begin
            r_err    <= 1'b0;
            r_frames <= '0;
            r_timer  <= '0;
          end else if (w_timeout) r_err <= 1'b1;
          else r_timer <= r_timer + 1'b1;
        end
        S_MEASURE: begin
          if (w_err_in) r_err <= 1'b1;
          if (frame_start_i) begin
            r_frames <= r_frames + 1'b1;
            r_timer  <= '0;
          end else if (w_timeout) r_err <= 1'b1;
          else r_timer <= r_timer + 1'b1;
        end
        S_EVAL: begin
          if (!w_last_tap) begin
            r_tap        <= r_tap + 1'b1;
            r_cur_start  <= w_cur_start_n;
            r_cur_len    <= w_cur_len_n;
            r_best_start <= w_best_start_n;
            r_best_len   <= w_best_len_n;
          end else begin
            r_res[r_k] <= w_result;
            if (w_lane_fail) lane_fail_o[r_k] <= 1'b1;
            r_tap        <= '0;
            r_cur_start  <= '0;
            r_cur_len    <= '0;
            r_best_start <= '0;
            r_best_len   <= '0;
            if (!w_last_lane) r_k <= r_k + 1'b1;
          end
        end
        S_FINAL: begin
          lane_delay_o <= r_res;
          delay_act_o  <= 1'b1;
          done_o       <= 1'b1;
          busy_o       <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_csi2_delay_calib.sv
module tb_csi2_delay_calib;
  localparam int P = 30;  // frame period in clocks

  logic            clk_i = 1'b0, rst_i = 1'b1, start_i = 1'b0;
  logic            frame_start_i = 1'b0, header_err_i = 1'b0, crc_err_i = 1'b0;
  logic [1:0][4:0] lane_delay_o;
  logic            delay_act_o, busy_o, done_o;
  logic [1:0]      lane_fail_o;

  csi2_delay_calib #(
    .DATA_LANES(2), .TAP_WIDTH(5), .DEFAULT_TAP(16), .SETTLE_CYCLES(4),
    .DWELL_FRAMES(2), .TIMEOUT_CYCLES(120), .MIN_WINDOW(3)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .frame_start_i(frame_start_i),
    .header_err_i(header_err_i), .crc_err_i(crc_err_i), .lane_delay_o(lane_delay_o),
    .delay_act_o(delay_act_o), .busy_o(busy_o), .done_o(done_o), .lane_fail_o(lane_fail_o)
  );

  always #5 clk_i = ~clk_i;

  // tap mode: 0 clean pass, 1 errors mid-window, 2 error only with the closing
  // frame start, 3 errors in SETTLE and with the opening frame (still a pass)
  logic [1:0] modes [2][32];
  bit         noframes = 1'b0;
  int         n_chk = 0, n_pass = 0;

  typedef struct { logic [1:0][4:0] d; logic [1:0] f; } exp_t;
  exp_t sb[$];

  // receiver/stimulus model and sweep monitor
  int  act_idx = 0, since = 1000, sweep_err = 0, double_err = 0;
  bit  prev_act = 0, prev_busy = 0;
  always @(negedge clk_i) begin
    logic [1:0] m;
    if (busy_o && !prev_busy) begin act_idx = 0; sweep_err = 0; double_err = 0; end
    if (delay_act_o) begin
      if (prev_act) double_err++;
      since = 0;
      if (act_idx < 64 && lane_delay_o[act_idx/32] !== 5'(act_idx % 32)) sweep_err++;
      act_idx++;
    end else since++;
    prev_act  = delay_act_o;
    prev_busy = busy_o;
    m = (busy_o && act_idx >= 1 && act_idx <= 64) ? modes[(act_idx-1)/32][(act_idx-1)%32] : 2'd0;
    frame_start_i = busy_o && !noframes && act_idx >= 1 && since >= 10 && ((since - 10) % P) == 0;
    header_err_i  = busy_o && ((m == 2'd1 && since == 10 + P/2) || (m == 2'd3 && (since == 1 || since == 10)));
    crc_err_i     = busy_o && ((m == 2'd1 && since == 10 + 3*P/2) || (m == 2'd2 && since == 10 + 2*P));
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic set_lane(input int lane, input int lo, input int hi, input logic [1:0] inm);
    for (int t = 0; t < 32; t++) modes[lane][t] = (t >= lo && t <= hi) ? inm : 2'd1;
  endtask

  function automatic void model(input logic [31:0] pass, output logic [4:0] res, output logic fail);
    int bs = 0, bl = 0, cs = 0, cl = 0;
    for (int t = 0; t < 32; t++) begin
      if (pass[t]) begin
        if (cl == 0) cs = t;
        cl++;
        if (cl > bl) begin bl = cl; bs = cs; end
      end else cl = 0;
    end
    fail = (bl < 3);
    res  = fail ? 5'd16 : 5'(bs + (bl - 1) / 2);
  endfunction

  task automatic run_cal(input string tag, input bit poke);
    exp_t e, g;
    logic [31:0] pv;
    bit got = 0;
    for (int l = 0; l < 2; l++) begin
      for (int t = 0; t < 32; t++) pv[t] = !noframes && (modes[l][t] == 2'd0 || modes[l][t] == 2'd3);
      model(pv, e.d[l], e.f[l]);
    end
    sb.push_back(e);
    @(negedge clk_i); start_i = 1'b1;
    @(negedge clk_i); start_i = 1'b0;
    chk({tag, "_busy_rise"}, 32'(busy_o), 32'd1);
    for (int c = 0; c < 20000 && !got; c++) begin
      @(negedge clk_i);
      start_i = poke && (c == 300 || c == 3000);
      if (done_o) got = 1;
    end
    start_i = 1'b0;
    if (!got) chk({tag, "_done_seen"}, 32'(done_o), 32'd1);
    else begin
      #1;
      g = sb.pop_front();
      chk({tag, "_lane_delay"}, 32'(lane_delay_o), 32'(g.d));
      chk({tag, "_lane_fail"},  32'(lane_fail_o),  32'(g.f));
      chk({tag, "_act_count"},  32'(act_idx),      32'd65);
      chk({tag, "_busy_fall"},  32'(busy_o),       32'd0);
      chk({tag, "_sweep_taps"}, 32'(sweep_err),    32'd0);
      chk({tag, "_act_width"},  32'(double_err),   32'd0);
      @(negedge clk_i);
      chk({tag, "_done_pulse"}, 32'(done_o), 32'd0);
    end
  endtask

  initial begin
    int snap;
    bit hit;
    repeat (3) @(negedge clk_i);
    rst_i = 1'b0;
    @(negedge clk_i);
    chk("rst_delay", 32'(lane_delay_o), 32'h210);
    chk("rst_act",   32'(delay_act_o),  32'd0);
    chk("rst_busy",  32'(busy_o),       32'd0);
    chk("rst_done",  32'(done_o),       32'd0);
    chk("rst_fail",  32'(lane_fail_o),  32'd0);

    set_lane(0, 10, 20, 2'd0); set_lane(1, 3, 8, 2'd0);
    run_cal("main", 1'b1);

    set_lane(0, 2, 5, 2'd0);
    for (int t = 20; t <= 23; t++) modes[0][t] = 2'd0;
    set_lane(1, 7, 8, 2'd0);
    run_cal("tie_short", 1'b0);

    set_lane(0, 28, 31, 2'd0); set_lane(1, 3, 8, 2'd0);
    run_cal("sweep_end", 1'b0);

    set_lane(0, 10, 20, 2'd0); modes[0][15] = 2'd2;
    set_lane(1, 3, 8, 2'd3);
    run_cal("err_edges", 1'b0);

    noframes = 1'b1;
    run_cal("timeout", 1'b0);
    noframes = 1'b0;

    // reset during MEASURE of lane 0, tap 5
    set_lane(0, 10, 20, 2'd0); set_lane(1, 3, 8, 2'd0);
    @(negedge clk_i); start_i = 1'b1;
    @(negedge clk_i); start_i = 1'b0;
    hit = 0;
    for (int c = 0; c < 2000 && !hit; c++) begin
      @(negedge clk_i);
      if (act_idx == 6 && since == 30) hit = 1;
    end
    chk("mid_reached", 32'(hit), 32'd1);
    #2 rst_i = 1'b1;
    #1;
    chk("mid_rst_delay", 32'(lane_delay_o), 32'h210);
    chk("mid_rst_busy",  32'(busy_o),       32'd0);
    chk("mid_rst_act",   32'(delay_act_o),  32'd0);
    chk("mid_rst_done",  32'(done_o),       32'd0);
    chk("mid_rst_fail",  32'(lane_fail_o),  32'd0);
    repeat (3) @(negedge clk_i);
    rst_i = 1'b0;
    snap = act_idx;
    repeat (100) @(negedge clk_i);
    chk("post_rst_acts", 32'(act_idx - snap), 32'd0);
    chk("post_rst_busy", 32'(busy_o), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
